// File: rtl/bias_add_sched_pkg.sv
// ============================================================================
// Module : bias_add_sched_pkg
// Brief  : Shared lane width, saturation bounds and FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bias_add_sched_pkg;

  localparam int LANE_W = 18;

  localparam logic signed [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic signed [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bias_add_sched_lane_sat.sv
// ============================================================================
// Module : bias_lane_sat
// Brief  : One lane: signed add, saturate to W bits, optional ReLU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bias_lane_sat
  import bias_add_sched_pkg::*;
#(
  parameter int W       = LANE_W,
  parameter int RELU_EN = 1
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_bias,
  output logic [W-1:0] o_res
);

  localparam logic [W-1:0] C_MAX = (W == LANE_W) ? SAT_MAX : {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_MIN = (W == LANE_W) ? SAT_MIN : {1'b1, {(W-1){1'b0}}};

  logic [W:0]   w_sum;
  logic [W-1:0] w_sat;

  assign w_sum = {i_acc[W-1], i_acc} + {i_bias[W-1], i_bias};

  // The two top bits of the W+1 bit sum disagree only on overflow.
  always_comb begin
    w_sat = w_sum[W-1:0];
    if (w_sum[W] != w_sum[W-1]) begin
      w_sat = w_sum[W] ? C_MIN : C_MAX;
    end
    o_res = w_sat;
    if ((RELU_EN != 0) && w_sat[W-1]) begin
      o_res = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bias_add_sched.sv
// ============================================================================
// Module : bias_add_sched
// Brief  : Two-stage bias add / saturate / ReLU pipeline with layer-pass FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bias_add_sched
  import bias_add_sched_pkg::*;
#(
  parameter int N_adder_tree  = 16,
  parameter int W             = LANE_W,
  parameter int N_GROUPS      = 4,
  parameter int PIX_PER_GROUP = 169,
  parameter int RELU_EN       = 1,
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [N_GROUPS*N_adder_tree*W-1:0] bias_all,
  input  logic [N_adder_tree*W-1:0]        in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [N_adder_tree*W-1:0]        out_data,
  output logic [GW-1:0]                    out_group,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             done
);

  localparam int PW = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;
  localparam int VW = N_adder_tree * W;

  state_t          r_state;
  logic [PW-1:0]   r_pix_cnt;
  logic [GW-1:0]   r_grp_cnt;
  logic            r_s1_valid;
  logic [VW-1:0]   r_s1_data;
  logic [VW-1:0]   r_s1_bias;
  logic [GW-1:0]   r_s1_grp;

  logic [VW-1:0]   w_bias_sel;
  logic [VW-1:0]   w_res;
  logic            w_adv;
  logic            w_accept;
  logic            w_pix_wrap;
  logic            w_last_pix;

  assign w_adv      = !out_valid || out_ready;
  assign in_ready   = (r_state == ST_RUN) && w_adv;
  assign w_accept   = in_valid && in_ready;
  assign w_pix_wrap = (r_pix_cnt == PW'(PIX_PER_GROUP - 1));
  assign w_last_pix = w_pix_wrap && (r_grp_cnt == GW'(N_GROUPS - 1));
  assign busy       = (r_state != ST_IDLE);
  // Nothing is accepted in DRAIN, so an empty stage 1 means this is the last pixel.
  assign done       = (r_state == ST_DRAIN) && out_valid && out_ready && !r_s1_valid;

  always_comb begin
    w_bias_sel = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (r_grp_cnt == GW'(g)) begin
        w_bias_sel = bias_all[g*VW +: VW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pix_cnt <= '0;
      r_grp_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_pix_cnt <= '0;
            r_grp_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_state <= ST_DRAIN;
            end
            if (w_pix_wrap) begin
              r_pix_cnt <= '0;
              if (!w_last_pix) begin
                r_grp_cnt <= r_grp_cnt + 1'b1;
              end
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_bias  <= '0;
      r_s1_grp   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_group  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= in_data;
        r_s1_bias <= w_bias_sel;
        r_s1_grp  <= r_grp_cnt;
      end
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data  <= w_res;
        out_group <= r_s1_grp;
      end
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_lane_sat #(
      .W       (W),
      .RELU_EN (RELU_EN)
    ) u_lane (
      .i_acc  (r_s1_data[i*W +: W]),
      .i_bias (r_s1_bias[i*W +: W]),
      .o_res  (w_res[i*W +: W])
    );
  end

endmodule

`default_nettype wire
